// File: rtl/ram_arbiter.sv
// Two-requester (CPU, video line fetch) arbiter for a single-port synchronous RAM.
// Default: fixed priority to video with a CPU starvation guard; define RAM_ARBITER_RR_EN for round-robin.
module ram_arbiter #(
    parameter int A            = 12,
    parameter int D            = 8,
    parameter int CPU_WAIT_MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [A-1:0] cpu_addr,
    input  logic [D-1:0] cpu_wdata,
    output logic         cpu_gnt,
    output logic         cpu_rvalid,
    output logic [D-1:0] cpu_rdata,
    input  logic         vid_req,
    input  logic [A-1:0] vid_addr,
    output logic         vid_gnt,
    output logic         vid_rvalid,
    output logic [D-1:0] vid_rdata,
    output logic         ram_cs,
    output logic         ram_rw,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_wdata,
    input  logic [D-1:0] ram_rdata
);

    typedef enum logic {OWN_CPU = 1'b0, OWN_VID = 1'b1} owner_e;

    logic         ram_cs_q, ram_cs_d;
    logic         ram_rw_q, ram_rw_d;
    logic [A-1:0] ram_addr_q, ram_addr_d;
    logic [D-1:0] ram_wdata_q, ram_wdata_d;
    owner_e       own_q, own_d;
    owner_e       last_owner_q, last_owner_d;
    logic         cpu_rvalid_q, cpu_rvalid_d;
    logic         vid_rvalid_q, vid_rvalid_d;
    logic         cpu_win;

`ifdef RAM_ARBITER_RR_EN
    // Contention goes to whoever did not win last; worst-case CPU wait is one cycle.
    assign cpu_win = cpu_req && (!vid_req || last_owner_q == OWN_VID);
`else
    localparam int WW = $clog2(CPU_WAIT_MAX + 1);

    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    // Video wins contention until the CPU has been refused CPU_WAIT_MAX cycles in a row.
    assign cpu_win = cpu_req && (!vid_req || wait_cnt_q == WW'(CPU_WAIT_MAX));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!cpu_req || cpu_gnt)
            wait_cnt_d = '0;
        else if (wait_cnt_q != WW'(CPU_WAIT_MAX))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wait_cnt_q <= '0;
        else        wait_cnt_q <= wait_cnt_d;
    end
`endif

    assign cpu_gnt = cpu_win;
    assign vid_gnt = vid_req && !cpu_win;

    always_comb begin
        ram_cs_d     = 1'b0;
        ram_rw_d     = ram_rw_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        own_d        = own_q;
        last_owner_d = last_owner_q;
        if (cpu_gnt) begin
            ram_cs_d     = 1'b1;
            ram_rw_d     = ~cpu_we;
            ram_addr_d   = cpu_addr;
            ram_wdata_d  = cpu_wdata;
            own_d        = OWN_CPU;
            last_owner_d = OWN_CPU;
        end else if (vid_gnt) begin
            ram_cs_d     = 1'b1;
            ram_rw_d     = 1'b1;
            ram_addr_d   = vid_addr;
            own_d        = OWN_VID;
            last_owner_d = OWN_VID;
        end
        // RAM returns data one cycle after it samples a read; route it back to its owner.
        cpu_rvalid_d = ram_cs_q && ram_rw_q && (own_q == OWN_CPU);
        vid_rvalid_d = ram_cs_q && ram_rw_q && (own_q == OWN_VID);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_cs_q     <= 1'b0;
            ram_rw_q     <= 1'b1;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            own_q        <= OWN_CPU;
            last_owner_q <= OWN_CPU;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
        end else begin
            ram_cs_q     <= ram_cs_d;
            ram_rw_q     <= ram_rw_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            own_q        <= own_d;
            last_owner_q <= last_owner_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rvalid_q <= vid_rvalid_d;
        end
    end

    assign ram_cs     = ram_cs_q;
    assign ram_rw     = ram_rw_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign vid_rvalid = vid_rvalid_q;
    assign cpu_rdata  = ram_rdata;
    assign vid_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a behavioural RAM and reference model.
module tb_ram_arbiter;

    localparam int WMAX = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        vid_req = 1'b0;
    logic [11:0] vid_addr = '0;
    logic        vid_gnt, vid_rvalid;
    logic [7:0]  vid_rdata;
    logic        ram_cs, ram_rw;
    logic [11:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    ram_arbiter #(.A(12), .D(8), .CPU_WAIT_MAX(WMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM
    logic [7:0] ram_mem [4096];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (!ram_rw) ram_mem[ram_addr] <= ram_wdata;
            else         ram_rdata <= ram_mem[ram_addr];
        end
    end

    typedef struct packed {
        logic        v;
        logic        vid;
        logic        rd;
        logic [11:0] a;
        logic [7:0]  wd;
    } acc_t;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  ref_mem [4096];
    logic [7:0]  cpu_q[$];
    logic [7:0]  vid_q[$];
    int          refused;
    bit          last_vid;
    acc_t        acc1, acc2;
    bit          e_rw;
    logic [11:0] e_addr;
    logic [7:0]  e_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cpu_q.delete();
        vid_q.delete();
        refused  = 0;
        last_vid = 1'b0;
        acc1     = '0;
        acc2     = '0;
        e_rw     = 1'b1;
        e_addr   = '0;
        e_wdata  = '0;
    endtask

    // One bus cycle: drive after the edge, check at negedge, commit the model for the next edge.
    task automatic step(input bit creq, input bit cwe, input logic [11:0] caddr, input logic [7:0] cwd,
                        input bit vreq, input logic [11:0] vaddr, output bit cg, output bit vg);
        bit ecg, evg, cpu_first;
        logic [11:0] a;
        @(posedge clk); #1;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        vid_req = vreq; vid_addr = vaddr;
        @(negedge clk);
        chk("ram_cs", ram_cs, acc1.v);
        if (acc1.v) begin
            e_rw = acc1.rd;
            e_addr = acc1.a;
            if (!acc1.vid) e_wdata = acc1.wd;
        end
        chk("ram_rw", ram_rw, e_rw);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wdata", ram_wdata, e_wdata);
        chk("cpu_rvalid", cpu_rvalid, acc2.v && acc2.rd && !acc2.vid);
        chk("vid_rvalid", vid_rvalid, acc2.v && acc2.rd && acc2.vid);
`ifdef RAM_ARBITER_RR_EN
        cpu_first = last_vid;
`else
        cpu_first = (refused == WMAX);
`endif
        ecg = creq && (!vreq || cpu_first);
        evg = vreq && !ecg;
        chk("cpu_gnt", cpu_gnt, ecg);
        chk("vid_gnt", vid_gnt, evg);
        if (creq && !ecg) refused = (refused < WMAX) ? refused + 1 : WMAX;
        else              refused = 0;
        if (ecg || evg) last_vid = evg;
        a = ecg ? caddr : vaddr;
        acc2 = acc1;
        acc1 = '{v: ecg || evg, vid: evg, rd: evg || !cwe, a: a, wd: cwd};
        if (ecg && cwe) ref_mem[a] = cwd;
        else if (ecg) cpu_q.push_back(ref_mem[a]);
        else if (evg) vid_q.push_back(ref_mem[a]);
        cg = ecg;
        vg = evg;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_req = 1'b0;
        vid_req = 1'b1;
        model_reset();
        #1;
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_vid_rvalid", vid_rvalid, 0);
        chk("rst_vid_gnt_follows_req", vid_gnt, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_cs_hold", ram_cs, 0);
        chk("rst_ram_rw", ram_rw, 1);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        vid_req = 1'b0;
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        bit g1, g2;
        for (int i = 0; i < n; i++) step(0, 0, 12'h0, 8'h0, 0, 12'h0, g1, g2);
    endtask

    // Scoreboard monitor: every rvalid must match the oldest outstanding read for that requester.
    always @(negedge clk) begin
        if (reset && cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL cpu_rvalid_unexpected: got 1 expected 0 at %0t", $time);
            end else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end
        if (reset && vid_rvalid) begin
            if (vid_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL vid_rvalid_unexpected: got 1 expected 0 at %0t", $time);
            end else chk("vid_rdata", vid_rdata, vid_q.pop_front());
        end
    end

    initial begin
        bit cg, vg;
        bit cpend, cwe, vpend;
        logic [11:0] ca, va;
        logic [7:0]  cw;
        string pat;
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[12'h005] = 8'hA5; ref_mem[12'h005] = 8'hA5;
        ram_mem[12'h000] = 8'h11; ref_mem[12'h000] = 8'h11;
        ram_mem[12'h001] = 8'h22; ref_mem[12'h001] = 8'h22;
        ram_mem[12'h002] = 8'h33; ref_mem[12'h002] = 8'h33;
        ram_mem[12'h003] = 8'h44; ref_mem[12'h003] = 8'h44;
        model_reset();
        do_reset();

        // Lone CPU read: grant same cycle, ram_cs next, rvalid two cycles after accept
        step(1, 0, 12'h005, 8'h00, 0, 12'h0, cg, vg);
        chk("lone_cpu_gnt", cg, 1);
        idle(3);

        // CPU write then video read of the same address on the next cycle
        step(1, 1, 12'h010, 8'h3C, 0, 12'h0, cg, vg);
        step(0, 0, 12'h000, 8'h00, 1, 12'h010, cg, vg);
        idle(3);

        // Back-to-back video reads
        for (int i = 0; i < 4; i++) step(0, 0, 12'h0, 8'h0, 1, 12'(i), cg, vg);
        idle(3);

        // Continuous contention straight from reset
        do_reset();
`ifdef RAM_ARBITER_RR_EN
        pat = "VCVCVCVC";
`else
        pat = "VVVCVVVC";
`endif
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 12'h020, 8'h00, 1, 12'h021, cg, vg);
            chk($sformatf("contend_%0d", i), vg, pat[i] == "V");
        end
        idle(3);

        // Reset right after a CPU read accept drops the access and its rvalid
        step(1, 0, 12'h030, 8'h00, 0, 12'h0, cg, vg);
        do_reset();
        idle(4);

        // Randomized traffic with requesters holding requests until granted
        cpend = 0; vpend = 0; cwe = 0; ca = '0; cw = '0; va = '0;
        for (int n = 0; n < 600; n++) begin
            if (!cpend && $urandom_range(0, 9) < 6) begin
                cpend = 1;
                cwe = 1'($urandom);
                ca = 12'($urandom_range(0, 31));
                cw = 8'($urandom);
            end
            if (!vpend && $urandom_range(0, 9) < 6) begin
                vpend = 1;
                va = 12'($urandom_range(0, 31));
            end
            step(cpend, cwe, ca, cw, vpend, va, cg, vg);
            if (cg) cpend = 0;
            if (vg) vpend = 0;
        end
        idle(4);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("vid_q_drained", vid_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
